pry_slot_queue: RTL

Slot-addressed holding buffer that sits directly upstream of the priority multiplexer and turns it into a streaming stage. Producers write data into numbered slots; each slot's occupancy bit forms the priority vector, and the lowest-index occupied slot is selected, removed and presented on a registered valid/ready output. Typical use is an out-of-order completion buffer or an interrupt/event collector whose consumer must see the lowest-numbered pending entry first.

---
 rtl/pry_slot_queue.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pry_slot_queue.sv
// Slot-addressed holding buffer feeding a radix-SPLIT priority multiplexer; lowest occupied slot streams out.
// Optional PRY_SLOT_QUEUE_BYPASS_EN: an accepted write into an empty queue with a free output loads the output directly.

module pry_slot_node #(
  parameter int SPLIT = 2,
  parameter int IDX_W = 5,
  parameter int DAT_W = 8
) (
  input  logic [SPLIT-1:0]            in_vld,
  input  logic [SPLIT-1:0][IDX_W-1:0] in_idx,
  input  logic [SPLIT-1:0][DAT_W-1:0] in_dat,
  output logic                        out_vld,
  output logic [IDX_W-1:0]            out_idx,
  output logic [DAT_W-1:0]            out_dat
);
  // Scan downward so the lowest valid child wins.
  always_comb begin
    out_vld = |in_vld;
    out_idx = in_idx[SPLIT-1];
    out_dat = in_dat[SPLIT-1];
    for (int k = SPLIT-1; k >= 0; k--) begin
      if (in_vld[k]) begin
        out_idx = in_idx[k];
        out_dat = in_dat[k];
      end
    end
  end
endmodule

module pry_slot_pmux #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  parameter int IDX_W          = 5,
  parameter int DAT_W          = 8
) (
  input  logic [WIDTH-1:0]            vld,
  input  logic [WIDTH-1:0][DAT_W-1:0] dat,
  output logic                        sel_vld,
  output logic [IDX_W-1:0]            sel_idx,
  output logic [DAT_W-1:0]            sel_dat
);
  function automatic int levels_f(int w, int s);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < w) begin
      p = p * s;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = levels_f(WIDTH, SPLIT);
  localparam int PAD    = SPLIT ** LEVELS;

  generate
    if (IMPLEMENTATION == 0) begin : g_tree
      logic [LEVELS:0][PAD-1:0]            nv;
      logic [LEVELS:0][PAD-1:0][IDX_W-1:0] ni;
      logic [LEVELS:0][PAD-1:0][DAT_W-1:0] nd;

      // Leaves beyond WIDTH are padding and never valid.
      for (genvar n = 0; n < PAD; n++) begin : g_leaf
        if (n < WIDTH) begin : g_real
          assign nv[0][n] = vld[n];
          assign nd[0][n] = dat[n];
        end else begin : g_pad
          assign nv[0][n] = 1'b0;
          assign nd[0][n] = '0;
        end
        assign ni[0][n] = IDX_W'(n);
      end

      for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar n = 0; n < PAD; n++) begin : g_node
          if (n < PAD / (SPLIT ** (l + 1))) begin : g_used
            pry_slot_node #(.SPLIT(SPLIT), .IDX_W(IDX_W), .DAT_W(DAT_W)) u_node (
              .in_vld  (nv[l][n*SPLIT +: SPLIT]),
              .in_idx  (ni[l][n*SPLIT +: SPLIT]),
              .in_dat  (nd[l][n*SPLIT +: SPLIT]),
              .out_vld (nv[l+1][n]),
              .out_idx (ni[l+1][n]),
              .out_dat (nd[l+1][n])
            );
          end else begin : g_idle
            assign nv[l+1][n] = 1'b0;
            assign ni[l+1][n] = '0;
            assign nd[l+1][n] = '0;
          end
        end
      end

      assign sel_vld = nv[LEVELS][0];
      assign sel_idx = ni[LEVELS][0];
      assign sel_dat = nd[LEVELS][0];
    end else begin : g_lin
      always_comb begin
        sel_vld = |vld;
        sel_idx = '0;
        sel_dat = dat[0];
        for (int i = WIDTH-1; i >= 0; i--) begin
          if (vld[i]) begin
            sel_idx = IDX_W'(i);
            sel_dat = dat[i];
          end
        end
      end
    end
  endgenerate
endmodule

module pry_slot_queue #(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 32,
  parameter int  SPLIT          = 2,
  parameter int  IMPLEMENTATION = 0,
  localparam int IDX_W          = $clog2(WIDTH),
  localparam int CNT_W          = $clog2(WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [IDX_W-1:0] wr_idx,
  input  DAT_T             wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [IDX_W-1:0] rd_idx,
  output DAT_T             rd_dat,
  output logic [WIDTH-1:0] occ,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam int DAT_W = $bits(DAT_T);

  logic [WIDTH-1:0][DAT_W-1:0] slot;
  logic [WIDTH-1:0]            wr_dec, sel_dec, slot_set, occ_nxt;
  logic                        in_range, wr_acc, out_free, load, byp;
  logic                        sel_vld;
  logic [IDX_W-1:0]            sel_idx;
  logic [DAT_W-1:0]            sel_dat;
  logic [CNT_W-1:0]            cnt_c;

  assign in_range = ({1'b0, wr_idx} < (IDX_W+1)'(WIDTH));

  always_comb begin
    wr_dec  = '0;
    sel_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr_dec[i]  = (wr_idx == IDX_W'(i));
      sel_dec[i] = (sel_idx == IDX_W'(i));
    end
  end

  // Only registered occupancy and wr_idx feed wr_rdy.
  assign wr_rdy   = !in_range || !(|(wr_dec & occ));
  assign wr_acc   = wr_vld && wr_rdy;
  assign out_free = !rd_vld || rd_rdy;
  assign load     = sel_vld && out_free;

`ifdef PRY_SLOT_QUEUE_BYPASS_EN
  assign byp = wr_acc && in_range && (occ == '0) && out_free;
`else
  assign byp = 1'b0;
`endif

  assign slot_set = (wr_acc && in_range && !byp) ? wr_dec : '0;
  assign occ_nxt  = (occ & ~(load ? sel_dec : '0)) | slot_set;

  pry_slot_pmux #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION),
    .IDX_W(IDX_W), .DAT_W(DAT_W)
  ) u_pmux (
    .vld     (occ),
    .dat     (slot),
    .sel_vld (sel_vld),
    .sel_idx (sel_idx),
    .sel_dat (sel_dat)
  );

  // Payload storage carries no reset; occ alone decides validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      if (slot_set[i]) slot[i] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      rd_vld <= 1'b0;
      rd_idx <= '0;
      rd_dat <= '0;
      err    <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (wr_acc && !in_range) err <= 1'b1;
      if (load) begin
        rd_vld <= 1'b1;
        rd_idx <= sel_idx;
        rd_dat <= DAT_T'(sel_dat);
      end else if (byp) begin
        rd_vld <= 1'b1;
        rd_idx <= wr_idx;
        rd_dat <= wr_dat;
      end else if (rd_vld && rd_rdy) begin
        rd_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    cnt_c = CNT_W'(rd_vld);
    for (int i = 0; i < WIDTH; i++)
      cnt_c = cnt_c + CNT_W'(occ[i]);
  end
  assign cnt = cnt_c;
endmodule
